// File: rtl/bram_pkg.sv
// Shared types and helpers for the byte-enabled dual-port block RAM.
// Holds the controller state encoding, the byte width and the byte-merge function.
package bram_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic {
      INIT,
      READY
   } state_t;

   function automatic logic [BYTE_W-1:0] merge_byte(
      input logic [BYTE_W-1:0] old_b,
      input logic [BYTE_W-1:0] new_b,
      input logic              en
   );
      return en ? new_b : old_b;
   endfunction

endpackage

// File: rtl/bram_init_ctrl.sv
// Post-reset clear sequencer: walks every word address once, then stays READY.
// init_busy, clr_addr and clr_we are all driven straight from registers.
module bram_init_ctrl import bram_pkg::*; #(
   parameter int unsigned DEPTH = 12,
   parameter int unsigned IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             init_busy,
   output logic [IDX_W-1:0] clr_addr,
   output logic             clr_we
);

   state_t state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= INIT;
         clr_addr  <= '0;
         init_busy <= 1'b1;
         clr_we    <= 1'b1;
      end else begin
         case (state)
            INIT: begin
               if (clr_addr == IDX_W'(DEPTH - 1)) begin
                  state     <= READY;
                  init_busy <= 1'b0;
                  clr_we    <= 1'b0;
               end else begin
                  clr_addr <= clr_addr + 1'b1;
               end
            end
            READY: ;
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: rtl/bram_dp_be.sv
// Simple dual-port block RAM with byte enables, registered read and post-reset clear.
// Define BRAM_WR_BYPASS_EN for write-first same-address collisions (default read-first).
module bram_dp_be import bram_pkg::*; #(
   parameter  int unsigned DATA_WIDTH = 32,
   parameter  int unsigned DEPTH      = 12,
   parameter  int unsigned ADDR_WIDTH = 12,
   localparam int unsigned BE_WIDTH   = DATA_WIDTH / BYTE_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [BE_WIDTH-1:0]   we,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [ADDR_WIDTH-1:0] raddr,
   input  logic [DATA_WIDTH-1:0] wdi,
   output logic [DATA_WIDTH-1:0] rdo,
   output logic                  rvalid,
   output logic                  init_busy
);

   localparam int unsigned         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

   (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [IDX_W-1:0]      clr_addr;
   logic                  clr_we;
   logic                  wr_in_range;
   logic                  rd_in_range;
   logic [IDX_W-1:0]      widx;
   logic [IDX_W-1:0]      ridx;
   logic                  user_wr;
   logic [DATA_WIDTH-1:0] rd_word;

   bram_init_ctrl #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_init_ctrl (
      .clk       (clk),
      .rst_n     (rst_n),
      .init_busy (init_busy),
      .clr_addr  (clr_addr),
      .clr_we    (clr_we)
   );

   // Range check uses one extra bit so DEPTH == 2**ADDR_WIDTH stays representable.
   assign wr_in_range = {1'b0, waddr} < DEPTH_L;
   assign rd_in_range = {1'b0, raddr} < DEPTH_L;
   assign widx        = waddr[IDX_W-1:0];
   assign ridx        = raddr[IDX_W-1:0];
   assign user_wr     = rst_n && !init_busy && wr_in_range && (|we);

   always_ff @(posedge clk) begin
      if (rst_n && clr_we) begin
         mem[clr_addr] <= '0;
      end else if (user_wr) begin
         for (int unsigned i = 0; i < BE_WIDTH; i++) begin
            mem[widx][i*BYTE_W +: BYTE_W] <= merge_byte(mem[widx][i*BYTE_W +: BYTE_W],
                                                        wdi[i*BYTE_W +: BYTE_W], we[i]);
         end
      end
   end

   always_comb begin
      rd_word = mem[ridx];
`ifdef BRAM_WR_BYPASS_EN
      if (user_wr && (widx == ridx)) begin
         for (int unsigned i = 0; i < BE_WIDTH; i++) begin
            rd_word[i*BYTE_W +: BYTE_W] = merge_byte(mem[ridx][i*BYTE_W +: BYTE_W],
                                                     wdi[i*BYTE_W +: BYTE_W], we[i]);
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdo    <= '0;
         rvalid <= 1'b0;
      end else if (!init_busy && re) begin
         rvalid <= 1'b1;
         rdo    <= rd_in_range ? rd_word : '0;
      end else begin
         rvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bram_dp_be.sv
// Directed self-checking bench for bram_dp_be at its default 32-bit x 12-word shape.
// Expected collision data follows BRAM_WR_BYPASS_EN when the bench is built with it.
module tb_bram_dp_be;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  we;
   logic        re;
   logic [11:0] waddr;
   logic [11:0] raddr;
   logic [31:0] wdi;
   logic [31:0] rdo;
   logic        rvalid;
   logic        init_busy;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   logic [31:0] exp_mem [12];

   bram_dp_be #(
      .DATA_WIDTH (32),
      .DEPTH      (12),
      .ADDR_WIDTH (12)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (we),
      .re        (re),
      .waddr     (waddr),
      .raddr     (raddr),
      .wdi       (wdi),
      .rdo       (rdo),
      .rvalid    (rvalid),
      .init_busy (init_busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      else
         n_pass++;
   endtask

   // Drive one cycle of inputs on the falling edge, sample 1 ns after the rising edge.
   task automatic cyc(input logic [3:0] w, input logic [11:0] wa, input logic [31:0] d,
                      input logic r, input logic [11:0] ra);
      @(negedge clk);
      we = w; waddr = wa; wdi = d; re = r; raddr = ra;
      @(posedge clk);
      #1;
   endtask

   task automatic read_chk(input string tag, input logic [11:0] ra, input logic [31:0] exp);
      cyc(4'h0, 12'd0, 32'h0, 1'b1, ra);
      check_eq(tag, rdo, exp);
      check_eq({tag, "_rvalid"}, 32'(rvalid), 32'd1);
   endtask

   task automatic init_phase(input logic [11:0] ra);
      for (int k = 0; k < 12; k++) begin
         cyc(4'hF, 12'd0, 32'h5555_5555, 1'b1, ra);
         check_eq($sformatf("init_busy_e%0d", k), 32'(init_busy), (k < 11) ? 32'd1 : 32'd0);
         check_eq($sformatf("init_rvalid_e%0d", k), 32'(rvalid), 32'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0; we = '0; re = 1'b0; waddr = '0; raddr = '0; wdi = '0;
      for (int a = 0; a < 12; a++) exp_mem[a] = 32'h0;

      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_init_busy", 32'(init_busy), 32'd1);
      check_eq("rst_rvalid", 32'(rvalid), 32'd0);
      check_eq("rst_rdo", rdo, 32'h0);
      rst_n = 1'b1;

      // Writes and reads offered during the clear must be ignored.
      init_phase(12'd0);
      for (int a = 0; a < 12; a++)
         read_chk($sformatf("clr_rd%0d", a), 12'(a), 32'h0);

      cyc(4'hF, 12'd3, 32'hDEAD_BEEF, 1'b0, 12'd0);
      check_eq("wr_rvalid_low", 32'(rvalid), 32'd0);
      cyc(4'b0010, 12'd3, 32'h0000_AA00, 1'b0, 12'd0);
      exp_mem[3] = 32'hDEAD_AAEF;
      read_chk("be_merge", 12'd3, 32'hDEAD_AAEF);
      cyc(4'h0, 12'd0, 32'h0, 1'b0, 12'd0);
      check_eq("rvalid_pulse", 32'(rvalid), 32'd0);
      check_eq("rdo_hold", rdo, 32'hDEAD_AAEF);

      cyc(4'hF, 12'd5, 32'h1234_5678, 1'b1, 12'd5);
`ifdef BRAM_WR_BYPASS_EN
      check_eq("collide_full", rdo, 32'h1234_5678);
`else
      check_eq("collide_full", rdo, 32'h0);
`endif
      exp_mem[5] = 32'h1234_5678;
      read_chk("after_collide", 12'd5, 32'h1234_5678);

      cyc(4'hF, 12'd7, 32'hCAFE_F00D, 1'b1, 12'd3);
      check_eq("indep_rd", rdo, 32'hDEAD_AAEF);
      exp_mem[7] = 32'hCAFE_F00D;
      read_chk("indep_wr", 12'd7, 32'hCAFE_F00D);

      cyc(4'b1001, 12'd7, 32'h1122_3344, 1'b1, 12'd7);
`ifdef BRAM_WR_BYPASS_EN
      check_eq("collide_part", rdo, 32'h11FE_F044);
`else
      check_eq("collide_part", rdo, 32'hCAFE_F00D);
`endif
      exp_mem[7] = 32'h11FE_F044;

      // Out-of-range writes, including ones whose low bits alias valid words.
      cyc(4'hF, 12'd12,   32'hFFFF_FFFF, 1'b0, 12'd0);
      cyc(4'hF, 12'd16,   32'hFFFF_FFFF, 1'b0, 12'd0);
      cyc(4'hF, 12'd21,   32'hFFFF_FFFF, 1'b0, 12'd0);
      cyc(4'hF, 12'd4095, 32'hFFFF_FFFF, 1'b0, 12'd0);
      for (int a = 0; a < 12; a++)
         read_chk($sformatf("oor_rb%0d", a), 12'(a), exp_mem[a]);
      read_chk("oor_rd12", 12'd12, 32'h0);
      read_chk("pre_alias", 12'd3, 32'hDEAD_AAEF);
      read_chk("oor_rd19", 12'd19, 32'h0);
      read_chk("oor_rd4095", 12'd4095, 32'h0);

      cyc(4'hF, 12'd0, 32'hFFFF_FFFF, 1'b0, 12'd0);
      read_chk("pre_rst_rd0", 12'd0, 32'hFFFF_FFFF);
      @(negedge clk);
      we = '0; re = 1'b0;
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_busy", 32'(init_busy), 32'd1);
      check_eq("mid_rst_rdo", rdo, 32'h0);
      check_eq("mid_rst_rvalid", 32'(rvalid), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      init_phase(12'd3);
      read_chk("reclr_rd0", 12'd0, 32'h0);
      read_chk("reclr_rd3", 12'd3, 32'h0);
      read_chk("reclr_rd7", 12'd7, 32'h0);
      read_chk("reclr_rd11", 12'd11, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bram_dp_be.md
# bram_dp_be

Parametrised simple dual-port block RAM with per-byte write enables, a one-cycle registered read, out-of-range protection and a post-reset clear sequencer that zeroes every word before first use. It replaces the fixed 12-word tap/data buffers in the user-project datapath (FIR tap and data storage), so coefficient and sample memories can be sized per instance and always start from a known state.

## Interface
- DATA_WIDTH, 32, word width in bits; multiple of 8
- DEPTH, 12, number of words; ≥2
- ADDR_WIDTH, 12, address width; 2**ADDR_WIDTH ≥ DEPTH
- BE_WIDTH, DATA_WIDTH/8, byte-enable width (derived, not overridden)

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- we  in  BE_WIDTH  byte write enables; bit i writes wdi[8i+7:8i]
- re  in  1  read enable
- waddr  in  ADDR_WIDTH  write word address
- raddr  in  ADDR_WIDTH  read word address
- wdi  in  DATA_WIDTH  write data
- rdo  out  DATA_WIDTH  read data, registered
- rvalid  out  1  one-cycle pulse: rdo updated by a read accepted on the previous edge
- init_busy  out  1  clear sequence running; accesses ignored

## Operation
- Reset values: rdo=0, rvalid=0, init_busy=1, clear counter=0, state=INIT. Array contents are not reset.
- State machine: INIT → READY only. INIT: one word per cycle is written with 0 at counter address; counter increments; on the edge writing address DEPTH-1, go to READY. READY: normal operation, no exit except reset.
- Reset asserted mid-INIT or mid-READY: return immediately to INIT, counter=0; full clear restarts after deassertion.
- During INIT: we and re are ignored, rvalid stays 0, rdo holds.
- Write (READY): for each set bit of we, the corresponding byte of word waddr takes wdi; unset bytes keep their value. we=0 performs no write.
- Read (READY, re=1): on the edge, rdo ← word raddr, rvalid ← 1. re=0: rdo holds, rvalid ← 0.
- Out of range (address ≥ DEPTH): write dropped, no array change; read returns rdo=0 with rvalid=1.
- Same-address read and write on one edge: read-first. rdo gets the pre-write word (see Configuration).
- Independent read and write to different addresses on the same edge are both performed.

## Timing
- Read latency 1 cycle: rdo/rvalid valid after the edge that samples re=1. Back-to-back reads give one word per cycle.
- Write latency 1 cycle: a read of the same address on the next edge returns the new data.
- Clear takes exactly DEPTH cycles. With rst_n released before edge 0, edges 0..DEPTH-1 clear addresses 0..DEPTH-1. init_busy drops after edge DEPTH-1. The first access is accepted on edge DEPTH.
- init_busy is a registered state output with no combinational path from inputs.

## Configuration
- BRAM_WR_BYPASS_EN defined: same-address collisions are write-first. rdo = per-byte merge, taking wdi bytes where we is set and old word bytes elsewhere. Out-of-range collisions still return 0.
- Not defined: read-first, as specified above. No bypass mux is synthesised.

## Structure
- Shared package bram_pkg holds:
  - the state typedef (INIT, READY)
  - the byte-width constant 8
  - the byte-merge function used by write and bypass paths
- Sub-module bram_init_ctrl holds the INIT/READY FSM and clear counter. It outputs init_busy, the clear address and the clear write strobe.
- The top-level module muxes clear vs. user writes and holds the inferred array (ram_style "block") and read register.

## Test plan
- Reset release, DEPTH=12 → init_busy=1 for edges 0..11, 0 from edge 12. A read of every address then returns 0x00000000 with rvalid=1.
- Write 0xDEADBEEF @3 with we=4'hF, then we=4'b0010 with wdi=0x0000AA00 @3, then read @3 → rdo=0xDEADAABEEF-merged value 0xDEADAAEF, rvalid pulse exactly 1 cycle.
- Same-edge write 0x12345678 @5 (old 0x0) and read @5 → rdo=0x00000000. With BRAM_WR_BYPASS_EN → 0x12345678. A follow-up read → 0x12345678 in both builds.
- Write @12 and @4095 (DEPTH=12) → array unchanged, verified by full readback. Read @12 → rdo=0, rvalid=1.
- Write 0xFFFFFFFF @0 after init, pulse rst_n low mid-operation, then read @0 after 12 clear cycles → 0x00000000. Reads issued during INIT → rvalid stays 0.
- DATA_WIDTH=64, DEPTH=1024, ADDR_WIDTH=10: random byte-enable traffic vs. scoreboard model → zero mismatches over 10k cycles.
